// File: rtl/spi_master_pkg.sv
// Shared types, defaults and mode helpers for the SPI master and its SCLK generator.
package spi_master_pkg;

  localparam int DEF_CMD_BITS           = 8;
  localparam int DEF_ADDR_BITS          = 8;
  localparam int DEF_PAYLOAD_BITS       = 16;
  localparam int DEF_CLKS_PER_HALF_SCLK = 2;
  localparam int DEF_NUM_CS             = 2;
  localparam int DEF_INTER_FRAME_CLKS   = 2;

  localparam logic CS_ASSERT   = 1'b0;
  localparam logic CS_DEASSERT = 1'b1;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_GAP
  } state_t;

  function automatic logic mode_cpol(input spi_mode_t m);
    return (m == SPI_MODE2) || (m == SPI_MODE3);
  endfunction

  function automatic logic mode_cpha(input spi_mode_t m);
    return (m == SPI_MODE1) || (m == SPI_MODE3);
  endfunction

  // Select-bus width never collapses to zero, even with a single chip select.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_sclk_gen.sv
// Half-period timer and SCLK register; flags which SCLK edges are leading/trailing.
module spi_master_sclk_gen
  import spi_master_pkg::*;
#(
  parameter int CLKS_PER_HALF_SCLK = DEF_CLKS_PER_HALF_SCLK
) (
  input  logic sysclk,
  input  logic rst,
  input  logic en,
  input  logic toggle_en,
  input  logic load,
  input  logic cpol,
  output logic sclk,
  output logic tick,
  output logic lead_edge,
  output logic trail_edge
);

  localparam int CNT_W = (CLKS_PER_HALF_SCLK > 1) ? $clog2(CLKS_PER_HALF_SCLK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_HALF_SCLK - 1);

  logic [CNT_W-1:0] half_cnt;

  assign tick       = en && (half_cnt == CNT_LAST);
  // An edge is leading when SCLK leaves its idle level, trailing when it returns.
  assign lead_edge  = tick && toggle_en && (sclk == cpol);
  assign trail_edge = tick && toggle_en && (sclk != cpol);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      half_cnt <= '0;
      sclk     <= 1'b0;
    end else if (load) begin
      half_cnt <= '0;
      sclk     <= cpol;
    end else if (en) begin
      half_cnt <= tick ? '0 : half_cnt + 1'b1;
      if (tick && toggle_en) begin
        sclk <= ~sclk;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master: one CMD+ADDR+PAYLOAD frame per request, MSB first, full duplex, runtime mode 0-3.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CMD_BITS           = DEF_CMD_BITS,
  parameter int ADDR_BITS          = DEF_ADDR_BITS,
  parameter int PAYLOAD_BITS       = DEF_PAYLOAD_BITS,
  parameter int CLKS_PER_HALF_SCLK = DEF_CLKS_PER_HALF_SCLK,
  parameter int NUM_CS             = DEF_NUM_CS,
  parameter int INTER_FRAME_CLKS   = DEF_INTER_FRAME_CLKS,
  localparam int FRAME_W           = CMD_BITS + ADDR_BITS + PAYLOAD_BITS,
  localparam int CS_W              = clog2_min1(NUM_CS)
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               i_tx_valid,
  output logic               o_tx_ready,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic [CS_W-1:0]    i_cs_sel,
  input  logic [1:0]         i_mode,
  input  logic               miso,
  output logic               sclk,
  output logic               mosi,
  output logic [NUM_CS-1:0]  cs_n,
  output logic [FRAME_W-1:0] o_rx_frame,
  output logic               o_rx_valid,
  output logic               o_busy
);

  localparam int BIT_CNT_W = $clog2(FRAME_W + 1);
  localparam int GAP_W     = $clog2(INTER_FRAME_CLKS + 1);
  localparam logic [BIT_CNT_W-1:0] BITS_ALL    = BIT_CNT_W'(FRAME_W);
  localparam logic [BIT_CNT_W-1:0] BITS_ALL_M1 = BIT_CNT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST    = GAP_W'(INTER_FRAME_CLKS - 1);

  state_t             state;
  spi_mode_t          mode_q;
  logic [FRAME_W-1:0] tx_sr;
  logic [FRAME_W-1:0] rx_sr;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [NUM_CS-1:0]  cs_dec;

  logic accept;
  logic cpha;
  logic gen_en;
  logic gen_toggle;
  logic gen_cpol;
  logic tick;
  logic lead_edge;
  logic trail_edge;
  logic sample;
  logic shift_out;
  logic last_sample;
  logic frame_done;

  assign o_tx_ready = (state == ST_IDLE);
  assign o_busy     = ~o_tx_ready;
  assign accept     = i_tx_valid && o_tx_ready;
  assign cpha       = mode_cpha(mode_q);

  assign gen_en     = (state == ST_LEAD) || (state == ST_SHIFT) || (state == ST_TRAIL);
  assign gen_toggle = (state == ST_SHIFT);
  assign gen_cpol   = accept ? mode_cpol(spi_mode_t'(i_mode)) : mode_cpol(mode_q);

  spi_master_sclk_gen #(
    .CLKS_PER_HALF_SCLK(CLKS_PER_HALF_SCLK)
  ) u_sclk_gen (
    .sysclk    (sysclk),
    .rst       (rst),
    .en        (gen_en),
    .toggle_en (gen_toggle),
    .load      (accept),
    .cpol      (gen_cpol),
    .sclk      (sclk),
    .tick      (tick),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge)
  );

  // CPHA=0 already presented the MSB in LEAD, so its final trailing edge must not shift.
  assign sample      = cpha ? trail_edge : lead_edge;
  assign shift_out   = cpha ? lead_edge : (trail_edge && (bit_cnt != BITS_ALL));
  assign last_sample = (bit_cnt == BITS_ALL) || (sample && (bit_cnt == BITS_ALL_M1));
  assign frame_done  = trail_edge && last_sample;

  // Out-of-range select leaves every line deasserted.
  always_comb begin
    cs_dec = {NUM_CS{CS_DEASSERT}};
    for (int i = 0; i < NUM_CS; i++) begin
      if (i_cs_sel == CS_W'(i)) begin
        cs_dec[i] = CS_ASSERT;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode_q     <= SPI_MODE0;
      cs_n       <= {NUM_CS{CS_DEASSERT}};
      mosi       <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      o_rx_frame <= '0;
      o_rx_valid <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            mode_q  <= spi_mode_t'(i_mode);
            cs_n    <= cs_dec;
            bit_cnt <= '0;
            rx_sr   <= '0;
            if (!mode_cpha(spi_mode_t'(i_mode))) begin
              mosi  <= i_frame[FRAME_W-1];
              tx_sr <= i_frame << 1;
            end else begin
              tx_sr <= i_frame;
            end
            state <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (tick) begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sample) begin
            rx_sr   <= {rx_sr[FRAME_W-2:0], miso};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (shift_out) begin
            mosi  <= tx_sr[FRAME_W-1];
            tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
          end
          if (frame_done) begin
            state <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            cs_n       <= {NUM_CS{CS_DEASSERT}};
            o_rx_frame <= rx_sr;
            o_rx_valid <= 1'b1;
            gap_cnt    <= '0;
            state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed scenarios plus random frames against a behavioural slave.
module tb_spi_master;

  localparam int H      = 2;
  localparam int NUM_CS = 3;   // three lines so that an index past the last line is encodable
  localparam int GAP    = 2;
  localparam int F      = 32;
  localparam int CS_W   = 2;

  logic            sysclk = 1'b0;
  logic            rst = 1'b1;
  logic            i_tx_valid = 1'b0;
  logic            o_tx_ready;
  logic [F-1:0]    i_frame = '0;
  logic [CS_W-1:0] i_cs_sel = '0;
  logic [1:0]      i_mode = '0;
  logic            miso;
  logic            sclk;
  logic            mosi;
  logic [NUM_CS-1:0] cs_n;
  logic [F-1:0]    o_rx_frame;
  logic            o_rx_valid;
  logic            o_busy;

  int n_checks = 0;
  int n_fail = 0;

  // slave / monitor state
  logic [1:0]   cur_mode = '0;
  bit           use_slave = 1'b0;
  logic [F-1:0] slave_word = '0;
  logic         slave_miso = 1'b0;
  int           slave_idx = 0;
  logic [F-1:0] slave_rx = '0;
  int           toggles = 0;
  int           rises = 0;
  int           samp_cnt = 0;
  int           cs_low[NUM_CS];
  int           rx_pulses = 0;
  int           high_run = 0;
  int           last_gap = 0;
  logic         sclk_prev = 1'b0;
  logic         mosi_prev = 1'b0;
  logic         busy_prev = 1'b0;

  int n;
  int base;

  always #5 sysclk = ~sysclk;

  assign miso = use_slave ? slave_miso : mosi;

  spi_master #(
    .CMD_BITS(8),
    .ADDR_BITS(8),
    .PAYLOAD_BITS(16),
    .CLKS_PER_HALF_SCLK(H),
    .NUM_CS(NUM_CS),
    .INTER_FRAME_CLKS(GAP)
  ) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .i_tx_valid(i_tx_valid),
    .o_tx_ready(o_tx_ready),
    .i_frame   (i_frame),
    .i_cs_sel  (i_cs_sel),
    .i_mode    (i_mode),
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .o_rx_frame(o_rx_frame),
    .o_rx_valid(o_rx_valid),
    .o_busy    (o_busy)
  );

  // Behavioural slave and bus monitor, evaluated on the falling system-clock edge.
  always @(negedge sysclk) begin
    logic lead;
    if (o_rx_valid) rx_pulses++;
    if (&cs_n) high_run++;
    else begin
      if (high_run > 0) last_gap = high_run;
      high_run = 0;
    end
    if (o_busy && !busy_prev) begin
      toggles = 0; rises = 0; samp_cnt = 0; slave_rx = '0;
      for (int i = 0; i < NUM_CS; i++) cs_low[i] = 0;
      if (!cur_mode[0]) begin
        slave_miso = slave_word[F-1];
        slave_idx = F - 2;
      end else begin
        slave_idx = F - 1;
      end
    end else if (o_busy && (sclk !== sclk_prev)) begin
      toggles++;
      if (sclk) rises++;
      lead = (sclk_prev == cur_mode[1]);
      if (cur_mode[0] ? !lead : lead) begin
        slave_rx = {slave_rx[F-2:0], mosi_prev};
        samp_cnt++;
      end
      if ((cur_mode[0] ? lead : !lead) && slave_idx >= 0) begin
        slave_miso = slave_word[slave_idx];
        slave_idx--;
      end
    end
    for (int i = 0; i < NUM_CS; i++) if (o_busy && !cs_n[i]) cs_low[i]++;
    sclk_prev = sclk;
    mosi_prev = mosi;
    busy_prev = o_busy;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  function automatic int exp_cs_low(input int line, input int sel);
    return (line == sel) ? (2 * F + 2) * H : 0;
  endfunction

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!o_tx_ready && k < 1000) begin tick(); k++; end
    check_eq({tag, "_ready"}, 64'(o_tx_ready), 64'(1));
  endtask

  task automatic wait_rx(input string tag);
    int k;
    k = 0;
    while (!o_rx_valid && k < 2000) begin tick(); k++; end
    check_eq({tag, "_rx_seen"}, 64'(o_rx_valid), 64'(1));
  endtask

  task automatic run_frame(input string tag, input logic [F-1:0] frame, input logic [1:0] mode,
                           input logic [CS_W-1:0] cs, input bit slave, input logic [F-1:0] sword);
    logic [F-1:0] exp_rx;
    wait_ready(tag);
    cur_mode = mode; use_slave = slave; slave_word = sword;
    i_frame = frame; i_mode = mode; i_cs_sel = cs; i_tx_valid = 1'b1;
    tick();
    i_tx_valid = 1'b0;
    i_frame = $urandom; i_mode = 2'($urandom_range(0, 3)); i_cs_sel = 2'($urandom_range(0, 3));
    check_eq({tag, "_busy"}, 64'(o_busy), 64'(1));
    wait_rx(tag);
    exp_rx = slave ? sword : frame;
    check_eq({tag, "_rx_frame"}, 64'(o_rx_frame), 64'(exp_rx));
    check_eq({tag, "_mosi_stream"}, 64'(slave_rx), 64'(frame));
    check_eq({tag, "_samples"}, 64'(samp_cnt), 64'(F));
    check_eq({tag, "_toggles"}, 64'(toggles), 64'(2 * F));
    check_eq({tag, "_rises"}, 64'(rises), 64'(F));
    for (int i = 0; i < NUM_CS; i++)
      check_eq($sformatf("%s_cs_low%0d", tag, i), 64'(cs_low[i]), 64'(exp_cs_low(i, int'(cs))));
    tick();
    check_eq({tag, "_rx_pulse_end"}, 64'(o_rx_valid), 64'(0));
    check_eq({tag, "_rx_hold"}, 64'(o_rx_frame), 64'(exp_rx));
    wait_ready(tag);
    check_eq({tag, "_sclk_idle"}, 64'(sclk), 64'(mode[1]));
  endtask

  initial begin
    for (int i = 0; i < NUM_CS; i++) cs_low[i] = 0;
    repeat (3) tick();
    check_eq("rst_cs_n", 64'(cs_n), 64'(3'b111));
    check_eq("rst_sclk", 64'(sclk), 64'(0));
    check_eq("rst_mosi", 64'(mosi), 64'(0));
    check_eq("rst_rx_valid", 64'(o_rx_valid), 64'(0));
    check_eq("rst_rx_frame", 64'(o_rx_frame), 64'(0));
    rst = 1'b0;
    tick();
    check_eq("rst_ready", 64'(o_tx_ready), 64'(1));
    check_eq("rst_busy", 64'(o_busy), 64'(0));

    run_frame("t1_mode0", 32'hA53CBEEF, 2'd0, 2'd0, 1'b0, 32'h0);
    run_frame("t2_mode3", 32'hA53CBEEF, 2'd3, 2'd1, 1'b0, 32'h0);
    run_frame("t3_mode1", 32'hC0FFEE11, 2'd1, 2'd0, 1'b1, 32'h12345678);
    run_frame("t3_mode2", 32'h5A5AF00D, 2'd2, 2'd1, 1'b1, 32'h12345678);

    // back-to-back requests with valid held high
    wait_ready("t4");
    cur_mode = 2'd0; use_slave = 1'b0;
    i_mode = 2'd0; i_cs_sel = 2'd0; i_frame = 32'h11111111; i_tx_valid = 1'b1;
    base = rx_pulses;
    tick();
    check_eq("t4_busy1", 64'(o_busy), 64'(1));
    i_frame = 32'h22222222;
    wait_rx("t4_f1");
    check_eq("t4_rx1", 64'(o_rx_frame), 64'(32'h11111111));
    n = 0;
    while (o_busy && n < 100) begin tick(); n++; end
    while (!o_busy && n < 100) begin tick(); n++; end
    i_tx_valid = 1'b0;
    check_eq("t4_busy2", 64'(o_busy), 64'(1));
    wait_rx("t4_f2");
    check_eq("t4_rx2", 64'(o_rx_frame), 64'(32'h22222222));
    check_eq("t4_gap_ok", 64'(last_gap >= GAP), 64'(1));
    tick();
    check_eq("t4_pulses", 64'(rx_pulses - base), 64'(2));

    // reset mid-frame
    wait_ready("t5");
    cur_mode = 2'd0; use_slave = 1'b0;
    i_mode = 2'd0; i_cs_sel = 2'd0; i_frame = 32'hF00DCAFE; i_tx_valid = 1'b1;
    tick();
    i_tx_valid = 1'b0;
    n = 0;
    while (samp_cnt < 10 && n < 500) begin tick(); n++; end
    check_eq("t5_reached_10", 64'(samp_cnt >= 10), 64'(1));
    base = rx_pulses;
    rst = 1'b1;
    tick();
    check_eq("t5_cs_n", 64'(cs_n), 64'(3'b111));
    check_eq("t5_sclk", 64'(sclk), 64'(0));
    check_eq("t5_rx_valid", 64'(o_rx_valid), 64'(0));
    rst = 1'b0;
    tick();
    check_eq("t5_ready", 64'(o_tx_ready), 64'(1));
    repeat (200) tick();
    check_eq("t5_no_pulse", 64'(rx_pulses - base), 64'(0));
    run_frame("t5_after", 32'h0F0F0F0F, 2'd0, 2'd0, 1'b0, 32'h0);

    run_frame("t6_bad_cs", 32'hDEADBEEF, 2'd0, 2'd3, 1'b0, 32'h0);

    for (int k = 0; k < 12; k++)
      run_frame($sformatf("rnd%0d", k), $urandom, 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
